// File: rtl/umul_pkg.sv
// Shared constants and state encoding for the shift-add multiply-accumulate unit.
package umul_pkg;

  // Default operand width.
  localparam int WIDTH_DEF = 32;
  // Number of shift-add iterations per operation (one per multiplier bit).
  localparam int ITERS     = 32;
  // Iteration counter width; wide enough to hold ITERS itself.
  localparam int CNT_W     = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/umul_addstep.sv
// One shift-add step: {carry, sum} = H + (sel ? A : 0), purely combinational.
module umul_addstep
  import umul_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] h_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic             sel_i,
  output logic [WIDTH:0]   sum_o
);

  logic [WIDTH-1:0] addend;

  // Gate the multiplicand by the current multiplier bit, then add with carry-out.
  always_comb begin
    addend = sel_i ? a_i : '0;
    sum_o  = {1'b0, h_i} + {1'b0, addend};
  end

endmodule

// File: rtl/umul_acc_seq.sv
// Sequential unsigned multiply-accumulate: Result = Multiplicand*Multiplier + Addend.
// Radix-2 shift-add over a {H, L} product register; fixed ITERS-cycle latency.
// H starts as the addend, so the accumulate costs nothing extra: the final
// value is at most 2^64-2^32 and never overflows the product register.
module umul_acc_seq
  import umul_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   Multiplicand,
  input  logic [WIDTH-1:0]   Multiplier,
  input  logic [WIDTH-1:0]   Addend,
  output logic [2*WIDTH-1:0] Result,
  output logic               busy,
  output logic               done
);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic               busy_q, done_q;
  logic [WIDTH:0]     sum;

  // Low half of P holds the not-yet-consumed multiplier bits; bit 0 selects the add.
  umul_addstep #(.WIDTH(WIDTH)) u_addstep (
    .h_i   (p_q[2*WIDTH-1:WIDTH]),
    .a_i   (a_q),
    .sel_i (p_q[0]),
    .sum_o (sum)
  );

  // Next-state of the datapath for one RUN iteration: sum into H, shift right by one.
  always_comb begin
    p_d   = {sum, p_q[WIDTH-1:1]};
    cnt_d = cnt_q + CNT_W'(1);
  end

  // FSM with registered busy/done; P only moves on accept and in RUN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      p_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= Multiplicand;
            p_q     <= {Addend, Multiplier};
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          p_q   <= p_d;
          cnt_q <= cnt_d;
          // No early exit: zero operands still take the full ITERS cycles.
          if (cnt_q == CNT_W'(ITERS - 1)) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign Result = p_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_umul_acc_seq.sv
// Directed bench for umul_acc_seq: latency, busy window, results, start
// during RUN, reset abort and back-to-back throughput.
module tb_umul_acc_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] Multiplicand, Multiplier, Addend;
  logic [63:0] Result;
  logic        busy, done;

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;

  umul_acc_seq #(.WIDTH(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .Multiplicand (Multiplicand),
    .Multiplier   (Multiplier),
    .Addend       (Addend),
    .Result       (Result),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  // One operation. inj_at > 0 pulses start with other operands at that
  // negedge of RUN; operands are scrambled right after acceptance.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, input logic [63:0] exp, input int inj_at);
    int n, busy_n;
    bit seen;
    @(negedge clk);
    Multiplicand = a; Multiplier = b; Addend = c; start = 1'b1;
    @(posedge clk);
    n = 0; busy_n = 0; seen = 0;
    while (!seen && n < 100) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        start = 1'b0;
        Multiplicand = $urandom; Multiplier = $urandom; Addend = $urandom;
      end
      if (n == inj_at) begin
        start = 1'b1;
        Multiplicand = ~a; Multiplier = b + 32'd7; Addend = ~c;
      end
      if (inj_at > 0 && n == inj_at + 1) start = 1'b0;
      if (busy) busy_n++;
      if (done) seen = 1;
    end
    chk({tag, "_lat"},  64'(n), 64'd33);
    chk({tag, "_busy"}, 64'(busy_n), 64'd32);
    chk({tag, "_res"},  Result, exp);
    @(negedge clk);
    chk({tag, "_pulse"}, {62'd0, busy, done}, 64'd0);
    chk({tag, "_hold"},  Result, exp);
  endtask

  initial begin
    int n, done_n, t_prev;
    bit seen;
    logic [31:0] ra, rb, rc;
    logic [63:0] rexp;

    reset = 1'b1; start = 1'b0;
    Multiplicand = '0; Multiplier = '0; Addend = '0;
    repeat (3) @(negedge clk);
    chk("rst_res",  Result, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    run_op("small", 32'd3, 32'd5, 32'd0, 64'h0000_0000_0000_000F, 0);
    run_op("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF_0000_0000, 0);
    run_op("div", 32'h0000_1234, 32'h0000_0010, 32'h0000_0007, 64'h0000_0000_0001_2347, 0);
    run_op("zero", 32'd0, 32'd0, 32'd9, 64'd9, 0);
    run_op("inj", 32'h0001_0000, 32'h0000_0100, 32'h0000_00AB, 64'h0000_0000_0100_00AB, 10);

    // Reset at iteration 16 with start held high during reset.
    @(negedge clk);
    Multiplicand = 32'h1111_1111; Multiplier = 32'h2222_2222; Addend = 32'h3; start = 1'b1;
    @(posedge clk);
    repeat (16) @(negedge clk);
    start = 1'b0;
    chk("pre_abort_busy", {63'd0, busy}, 64'd1);
    reset = 1'b1; start = 1'b1;
    #1;
    chk("abort_async", {busy, done, 62'd0} | Result, 64'd0);
    done_n = 0;
    repeat (3) begin
      @(negedge clk);
      if (done || busy || Result != 0) done_n++;
    end
    chk("abort_held", 64'(done_n), 64'd0);
    start = 1'b0; reset = 1'b0;
    done_n = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) done_n++;
    end
    chk("abort_nodone", 64'(done_n), 64'd0);
    run_op("post_rst", 32'd2, 32'd2, 32'd1, 64'd5, 0);

    // Back-to-back with start held high: new operands each time done is seen.
    @(negedge clk);
    ra = $urandom; rb = $urandom; rc = $urandom;
    Multiplicand = ra; Multiplier = rb; Addend = rc; start = 1'b1;
    t_prev = 0;
    for (int k = 0; k < 3; k++) begin
      rexp = 64'(ra) * 64'(rb) + 64'(rc);
      n = 0; seen = 0;
      while (!seen && n < 100) begin
        @(negedge clk);
        n++;
        if (done) seen = 1;
      end
      chk($sformatf("b2b%0d_res", k), Result, rexp);
      if (k > 0) chk($sformatf("b2b%0d_gap", k), 64'(cyc - t_prev), 64'd34);
      else       chk("b2b0_seen", 64'(seen), 64'd1);
      t_prev = cyc;
      ra = $urandom; rb = $urandom; rc = $urandom;
      Multiplicand = ra; Multiplier = rb; Addend = rc;
    end
    start = 1'b0;
    repeat (40) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
